exhaustive_vector_checker: RTL and testbench

- Parametrised, synthesisable sequential checker for small combinational blocks such as the textbook gate-level figure circuits.
- Drives every input combination 0 .. 2^N_IN-1 onto a device under test. Waits a programmable settle time per vector.
- Compares the device's outputs against a golden model's outputs and records the mismatch count and the first failing vector.
- Sits beside a device instance and its continuous-assignment golden twin, under a start/busy/done handshake.

---
 rtl/exhaustive_vector_checker.sv | 136 +++++++++++++
 tb/tb_exhaustive_vector_checker.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/exhaustive_vector_checker.sv
// rtl/exhaustive_vector_checker.sv - exhaustive input sweep comparing a device against its golden model
//
// Ports:
//   clock, reset_b        rising-edge clock, asynchronous active-low reset
//   start                 begin a sweep (accepted in IDLE or DONE only)
//   abort                 synchronous return to IDLE, results retained
//   stop_on_fail          end the sweep at the first mismatch (latched with start)
//   dut_out, ref_out      device and golden-model outputs for the current vector
//   vec_out               vector driven to both models
//   busy, done, pass      sweep status
//   fail_seen, err_cnt    mismatch flag and count for this sweep
//   first_fail_vec        vector of the first mismatch, 0 if none
module exhaustive_vector_checker #(
    parameter int N_IN       = 4,
    parameter int N_OUT      = 1,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clock,
    input  logic             reset_b,
    input  logic             start,
    input  logic             abort,
    input  logic             stop_on_fail,
    input  logic [N_OUT-1:0] dut_out,
    input  logic [N_OUT-1:0] ref_out,
    output logic [N_IN-1:0]  vec_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail_seen,
    output logic [N_IN:0]    err_cnt,
    output logic [N_IN-1:0]  first_fail_vec
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // The settle counter only ever holds 0 .. SETTLE_CYC-1.
    localparam int              CNT_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0]  VEC_LAST = {N_IN{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic [N_IN:0]    err_q, err_d;
    logic [N_IN-1:0]  ffv_q, ffv_d;
    logic             fail_q, fail_d;
    logic             sof_q, sof_d;
    logic             mismatch;

    assign mismatch = (dut_out != ref_out);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        fail_d  = fail_q;
        sof_d   = sof_q;
        if (abort) begin
            // Results are deliberately kept so a stalled sweep can be inspected.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d = ST_WAIT;
                        vec_d   = '0;
                        cnt_d   = RELOAD;
                        err_d   = '0;
                        ffv_d   = '0;
                        fail_d  = 1'b0;
                        sof_d   = stop_on_fail;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_d = ST_CHECK;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        // N_IN+1 bits hold 2^N_IN, so this can never wrap.
                        err_d = err_q + (N_IN + 1)'(1);
                        if (!fail_q) begin
                            ffv_d  = vec_q;
                            fail_d = 1'b1;
                        end
                    end
                    if ((vec_q == VEC_LAST) || (mismatch && sof_q)) begin
                        state_d = ST_DONE;
                    end else begin
                        vec_d   = vec_q + N_IN'(1);
                        cnt_d   = RELOAD;
                        state_d = ST_WAIT;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            ffv_q   <= '0;
            fail_q  <= 1'b0;
            sof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            fail_q  <= fail_d;
            sof_q   <= sof_d;
        end
    end

    assign vec_out        = vec_q;
    assign busy           = (state_q == ST_WAIT) || (state_q == ST_CHECK);
    assign done           = (state_q == ST_DONE);
    assign pass           = done && (err_q == '0);
    assign fail_seen      = fail_q;
    assign err_cnt        = err_q;
    assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_exhaustive_vector_checker.sv
// tb/tb_exhaustive_vector_checker.sv - directed vector bench for exhaustive_vector_checker
module tb_exhaustive_vector_checker;

    logic clock = 1'b0;
    logic reset_b = 1'b0;
    always #5 clock = ~clock;

    // Instance A: N_IN=4, N_OUT=1, SETTLE_CYC=2
    logic        start_a = 1'b0, abort_a = 1'b0, sof_a = 1'b0;
    logic [15:0] mask_a = 16'h0;
    logic        ref_a, dut_a;
    logic [3:0]  vec_a, ffv_a;
    logic [4:0]  err_a;
    logic        busy_a, done_a, pass_a, fs_a;

    assign ref_a = ^vec_a;
    assign dut_a = ref_a ^ mask_a[vec_a];

    exhaustive_vector_checker #(.N_IN(4), .N_OUT(1), .SETTLE_CYC(2)) u_a (
        .clock(clock), .reset_b(reset_b), .start(start_a), .abort(abort_a),
        .stop_on_fail(sof_a), .dut_out(dut_a), .ref_out(ref_a),
        .vec_out(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .fail_seen(fs_a), .err_cnt(err_a), .first_fail_vec(ffv_a)
    );

    // Instance B: N_IN=2, N_OUT=3, SETTLE_CYC=1, bit 2 flipped at vector 3
    logic        start_b = 1'b0, abort_b = 1'b0;
    logic [2:0]  ref_b, dut_b;
    logic [1:0]  vec_b, ffv_b;
    logic [2:0]  err_b;
    logic        busy_b, done_b, pass_b, fs_b;

    assign ref_b = {vec_b, ^vec_b};
    assign dut_b = ref_b ^ ((vec_b == 2'd3) ? 3'b100 : 3'b000);

    exhaustive_vector_checker #(.N_IN(2), .N_OUT(3), .SETTLE_CYC(1)) u_b (
        .clock(clock), .reset_b(reset_b), .start(start_b), .abort(abort_b),
        .stop_on_fail(1'b0), .dut_out(dut_b), .ref_out(ref_b),
        .vec_out(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .fail_seen(fs_b), .err_cnt(err_b), .first_fail_vec(ffv_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic        sof;
        logic [15:0] mask;
        int          cyc;
        int          err;
        int          ffv;
        int          vec;
        int          pass;
        int          fs;
    } vec_rec_t;

    vec_rec_t tbl[7];

    // Pulse start, then count edges until done; vec_out must equal c/3 at
    // edge t0+c while the sweep is running (3 cycles per vector).
    task automatic run_a(input logic sof, input logic [15:0] mask,
                         output int cyc, output int seq_err, output int done_t1);
        @(negedge clock);
        mask_a  = mask;
        sof_a   = sof;
        start_a = 1'b1;
        @(posedge clock);
        #1;
        start_a = 1'b0;
        sof_a   = ~sof;
        done_t1 = done_a;
        cyc     = 0;
        seq_err = 0;
        while (cyc < 200) begin
            @(posedge clock);
            #1;
            cyc++;
            if (done_a) break;
            if (vec_a != 4'(cyc / 3)) seq_err++;
            if (!busy_a) seq_err++;
        end
    endtask

    initial begin
        int cyc, seq_err, dt1;

        tbl[0] = '{1'b0, 16'h0000, 48, 0,  0,  15, 1, 0};
        tbl[1] = '{1'b0, 16'h8002, 48, 2,  1,  15, 0, 1};
        tbl[2] = '{1'b1, 16'h0002, 6,  1,  1,  1,  0, 1};
        tbl[3] = '{1'b0, 16'hFFFF, 48, 16, 0,  15, 0, 1};
        tbl[4] = '{1'b1, 16'h0001, 3,  1,  0,  0,  0, 1};
        tbl[5] = '{1'b1, 16'h8000, 48, 1,  15, 15, 0, 1};
        tbl[6] = '{1'b1, 16'h0220, 18, 1,  5,  5,  0, 1};

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_vec", vec_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_pass", pass_a, 0);
        check("rst_err", err_a, 0);
        check("rst_fs", fs_a, 0);
        @(negedge clock);
        reset_b = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_a(tbl[i].sof, tbl[i].mask, cyc, seq_err, dt1);
            check($sformatf("t%0d_done_after_start", i), dt1, 0);
            check($sformatf("t%0d_cycles", i), cyc, tbl[i].cyc);
            check($sformatf("t%0d_seq", i), seq_err, 0);
            check($sformatf("t%0d_err", i), err_a, tbl[i].err);
            check($sformatf("t%0d_ffv", i), ffv_a, tbl[i].ffv);
            check($sformatf("t%0d_vec", i), vec_a, tbl[i].vec);
            check($sformatf("t%0d_pass", i), pass_a, tbl[i].pass);
            check($sformatf("t%0d_fs", i), fs_a, tbl[i].fs);
            check($sformatf("t%0d_busy", i), busy_a, 0);
            // Results hold in DONE
            repeat (3) @(posedge clock);
            #1;
            check($sformatf("t%0d_hold", i), {done_a, vec_a}, {1'b1, 4'(tbl[i].vec)});
        end

        // Abort at vec 6 with start also high: abort wins, results retained
        @(negedge clock);
        mask_a = 16'h0004;
        sof_a = 1'b0;
        start_a = 1'b1;
        @(posedge clock);
        #1;
        start_a = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        check("ab_vec_before", vec_a, 6);
        abort_a = 1'b1;
        start_a = 1'b1;
        @(posedge clock);
        #1;
        abort_a = 1'b0;
        start_a = 1'b0;
        check("ab_busy", busy_a, 0);
        check("ab_done", done_a, 0);
        check("ab_pass", pass_a, 0);
        check("ab_vec", vec_a, 6);
        check("ab_err", err_a, 1);
        check("ab_ffv", ffv_a, 2);
        check("ab_fs", fs_a, 1);
        repeat (2) @(posedge clock);
        #1;
        check("ab_idle_stays", {busy_a, vec_a}, {1'b0, 4'd6});

        // Restart clears counters and begins at vector 0
        @(negedge clock);
        mask_a = 16'h0000;
        start_a = 1'b1;
        @(posedge clock);
        #1;
        start_a = 1'b0;
        check("rs_vec", vec_a, 0);
        check("rs_err", err_a, 0);
        check("rs_ffv", ffv_a, 0);
        check("rs_fs", fs_a, 0);
        check("rs_busy", busy_a, 1);
        cyc = 0;
        while (cyc < 200 && !done_a) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        check("rs_cycles", cyc, 48);
        check("rs_pass", pass_a, 1);

        // Start held high throughout busy; async reset mid-WAIT at vec 9
        @(negedge clock);
        mask_a = 16'h0004;
        start_a = 1'b1;
        @(posedge clock);
        #1;
        repeat (27) @(posedge clock);
        #1;
        check("sh_vec9", vec_a, 9);
        check("sh_err", err_a, 1);
        check("sh_busy", busy_a, 1);
        #2;
        reset_b = 1'b0;
        #1;
        check("ar_vec", vec_a, 0);
        check("ar_busy", busy_a, 0);
        check("ar_done", done_a, 0);
        check("ar_pass", pass_a, 0);
        check("ar_err", err_a, 0);
        check("ar_ffv", ffv_a, 0);
        check("ar_fs", fs_a, 0);
        start_a = 1'b0;
        @(negedge clock);
        reset_b = 1'b1;

        // Instance B: multi-bit outputs, single bit-2 mismatch at vector 3
        @(negedge clock);
        start_b = 1'b1;
        @(posedge clock);
        #1;
        start_b = 1'b0;
        check("b_busy", busy_b, 1);
        cyc = 0;
        while (cyc < 100 && !done_b) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        check("b_cycles", cyc, 8);
        check("b_err", err_b, 1);
        check("b_ffv", ffv_b, 3);
        check("b_fs", fs_b, 1);
        check("b_pass", pass_b, 0);
        check("b_vec", vec_b, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
